// File: rtl/mmio_pwm_led.sv
// Memory-mapped N-channel PWM LED controller: shared prescaler and period counter,
// per-channel double-buffered duty, optional breathe fade, polarity inversion.
module mmio_pwm_led #(
    parameter int          NUM_CH    = 4,
    parameter int          PWM_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_wen,
    input  logic [31:0]       mem_wa,
    input  logic [31:0]       mem_wd,
    input  logic [2:0]        mem_funct3,
    input  logic [31:0]       mem_ra,
    output logic [31:0]       rd_data,
    output logic              rd_hit,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam int W = PWM_WIDTH;

    logic          en, inv;
    logic [15:0]   prescale, prescale_act, pre_cnt;
    logic [W-1:0]  cnt;
    logic [W-1:0]  duty   [NUM_CH];
    logic [W-1:0]  shadow [NUM_CH];
    logic [W-1:0]  level  [NUM_CH];
    logic [W-1:0]  eff    [NUM_CH];
    logic          fade   [NUM_CH];
    logic          dir    [NUM_CH];
    logic [31:0]   view   [64];

    logic          wr_hit, rd_hit_c, wr_ok, wr_en, tick, period_end;
    logic [5:0]    wr_idx;
    logic [31:0]   wr_mask, wr_data, wr_word;
    logic          unused_ok;

    assign wr_hit     = (mem_wa[31:8] == BASE_ADDR[31:8]);
    assign rd_hit_c   = (mem_ra[31:8] == BASE_ADDR[31:8]);
    assign wr_idx     = mem_wa[7:2];
    assign tick       = en && (pre_cnt == prescale_act);
    assign period_end = tick && (cnt == {W{1'b1}});
    assign unused_ok  = ^{mem_ra[1:0], wr_word[31:16]};

    // Word-level view of the register map; shared by reads and write merging.
    always_comb begin
        for (int i = 0; i < 64; i++) view[i] = '0;
        view[0] = {30'd0, inv, en};
        view[1] = {16'd0, prescale};
        view[2] = 32'(cnt);
        for (int c = 0; c < NUM_CH; c++) begin
            view[4 + 2*c] = 32'(duty[c]);
            view[5 + 2*c] = {31'd0, fade[c]};
        end
    end

    always_comb begin
        wr_mask = '0;
        wr_data = '0;
        wr_ok   = 1'b0;
        case (mem_funct3)
            3'b000: begin
                wr_ok   = 1'b1;
                wr_mask = 32'h0000_00FF << {mem_wa[1:0], 3'b000};
                wr_data = {4{mem_wd[7:0]}};
            end
            3'b001: begin
                wr_ok   = !mem_wa[0];
                wr_mask = mem_wa[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                wr_data = {2{mem_wd[15:0]}};
            end
            3'b010: begin
                wr_ok   = (mem_wa[1:0] == 2'b00);
                wr_mask = '1;
                wr_data = mem_wd;
            end
            default: ;
        endcase
        wr_word = (view[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        wr_en   = mem_wen && wr_hit && wr_ok;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) eff[c] = fade[c] ? level[c] : shadow[c];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en           <= 1'b0;
            inv          <= 1'b0;
            prescale     <= '0;
            prescale_act <= '0;
            pre_cnt      <= '0;
            cnt          <= '0;
            rd_data      <= '0;
            rd_hit       <= 1'b0;
            pwm_out      <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                duty[c]   <= '0;
                shadow[c] <= '0;
                level[c]  <= '0;
                fade[c]   <= 1'b0;
                dir[c]    <= 1'b0;
            end
        end else begin
            if (wr_en && wr_idx == 6'd0) begin
                en  <= wr_word[0];
                inv <= wr_word[1];
            end
            if (wr_en && wr_idx == 6'd1) prescale <= wr_word[15:0];

            rd_hit  <= rd_hit_c;
            rd_data <= rd_hit_c ? view[mem_ra[7:2]] : '0;

            // New PRESCALE values are only picked up at a tick so the current interval completes.
            if (!en) begin
                pre_cnt      <= '0;
                cnt          <= '0;
                prescale_act <= prescale;
            end else if (tick) begin
                pre_cnt      <= '0;
                cnt          <= cnt + 1'b1;
                prescale_act <= prescale;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end

            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && wr_idx == 6'(4 + 2*c)) duty[c] <= wr_word[W-1:0];
                if (wr_en && wr_idx == 6'(5 + 2*c)) fade[c] <= wr_word[0];
                if (!en || period_end) shadow[c] <= duty[c];

                if (!fade[c]) begin
                    level[c] <= '0;
                    dir[c]   <= 1'b0;
                end else if (!dir[c] && level[c] > shadow[c]) begin
                    level[c] <= shadow[c];
                    dir[c]   <= 1'b1;
                end else if (period_end) begin
                    if (!dir[c]) begin
                        if (level[c] < shadow[c]) level[c] <= level[c] + 1'b1;
                        else                      dir[c]   <= 1'b1;
                    end else begin
                        if (level[c] != '0) level[c] <= level[c] - 1'b1;
                        else                dir[c]   <= 1'b0;
                    end
                end

                pwm_out[c] <= (en && (cnt < eff[c])) ^ inv;
            end
        end
    end
endmodule

// File: tb/tb_mmio_pwm_led.sv
// Scoreboard bench for mmio_pwm_led: expected read words and per-period high counts
// are queued as stimulus is applied and popped when the DUT output is sampled.
module tb_mmio_pwm_led;
    localparam int          NUM_CH = 4;
    localparam int          PW     = 8;
    localparam int          PERIOD = 1 << PW;
    localparam logic [31:0] BASE   = 32'hFFFF_FF00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;

    typedef struct {
        bit          is_rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f3;
    } op_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_wen = 1'b0;
    logic [31:0]       mem_wa = '0;
    logic [31:0]       mem_wd = '0;
    logic [2:0]        mem_funct3 = '0;
    logic [31:0]       mem_ra = '0;
    logic [31:0]       rd_data;
    logic              rd_hit;
    logic [NUM_CH-1:0] pwm_out;

    int          checks = 0;
    int          failures = 0;
    logic [32:0] rd_q[$];
    int          cnt_q[$];
    int          hi_cnt[NUM_CH];

    mmio_pwm_led #(.NUM_CH(NUM_CH), .PWM_WIDTH(PW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_ra(mem_ra), .rd_data(rd_data), .rd_hit(rd_hit),
        .pwm_out(pwm_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] a_duty(input int i);
        return BASE + 32'h10 + 32'(8 * i);
    endfunction

    function automatic logic [31:0] a_fade(input int i);
        return BASE + 32'h14 + 32'(8 * i);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        @(negedge clk);
        mem_wen = 1'b1; mem_wa = a; mem_wd = d; mem_funct3 = f3;
        @(negedge clk);
        mem_wen = 1'b0;
    endtask

    task automatic wrw(input logic [31:0] a, input logic [31:0] d);
        wr(a, d, 3'b010);
    endtask

    task automatic issue_rd(input logic [31:0] a, input logic hit, input logic [31:0] d);
        mem_ra = a;
        rd_q.push_back({hit, d});
        @(negedge clk);
    endtask

    task automatic count_win(input int n);
        for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
        repeat (n) begin
            for (int c = 0; c < NUM_CH; c++) hi_cnt[c] += int'(pwm_out[c]);
            @(negedge clk);
        end
    endtask

    task automatic align_ch0(output bit ok);
        logic prev;
        prev = pwm_out[0];
        ok = 1'b0;
        for (int i = 0; i < 4 * PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[0] && !prev) begin
                ok = 1'b1;
                return;
            end
            prev = pwm_out[0];
        end
    endtask

    task automatic test_reset();
        logic [32:0] e;
        logic [31:0] addrs[4];
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (pwm_out !== '0 || rd_hit !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got pwm=%b hit=%b data=%h, expected all zero", pwm_out, rd_hit, rd_data);
        end
        addrs = '{A_CTRL, A_PRE, a_duty(0), a_fade(0)};
        for (int i = 0; i < 4; i++) begin
            issue_rd(addrs[i], 1'b1, 32'h0);
            e = rd_q.pop_front();
            checks++;
            if ({rd_hit, rd_data} !== e) begin
                failures++;
                $display("FAIL reset_read %h: got hit=%b data=%h, expected hit=%b data=%h", addrs[i], rd_hit, rd_data, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_regs();
        op_t ops[$];
        logic [32:0] e;
        ops.push_back('{0, A_PRE,           32'h12,        3'b010});
        ops.push_back('{0, BASE + 32'h5,    32'hAB,        3'b000});
        ops.push_back('{1, A_PRE,           32'hAB12,      3'b000});
        ops.push_back('{0, BASE + 32'h7,    32'hFFFF,      3'b001});
        ops.push_back('{0, BASE + 32'h6,    32'h1234_5678, 3'b010});
        ops.push_back('{0, A_PRE,           32'h5555,      3'b011});
        ops.push_back('{1, A_PRE,           32'hAB12,      3'b000});
        ops.push_back('{0, A_PRE,           32'h3456,      3'b001});
        ops.push_back('{1, A_PRE,           32'h3456,      3'b000});
        ops.push_back('{0, a_duty(0),       32'h12,        3'b010});
        ops.push_back('{0, BASE + 32'h11,   32'hAB,        3'b000});
        ops.push_back('{1, a_duty(0),       32'h12,        3'b000});
        ops.push_back('{0, BASE + 32'h10,   32'h9C,        3'b000});
        ops.push_back('{1, a_duty(0),       32'h9C,        3'b000});
        ops.push_back('{0, a_fade(0),       32'hFFFF_FFFF, 3'b010});
        ops.push_back('{1, a_fade(0),       32'h1,         3'b000});
        ops.push_back('{0, a_fade(0),       32'h0,         3'b010});
        ops.push_back('{0, A_STAT,          32'h5,         3'b010});
        ops.push_back('{1, A_STAT,          32'h0,         3'b000});
        ops.push_back('{0, BASE + 32'h30,   32'hFF,        3'b010});
        ops.push_back('{1, BASE + 32'h30,   32'h0,         3'b000});
        ops.push_back('{1, BASE + 32'h0C,   32'h0,         3'b000});
        ops.push_back('{0, A_PRE,           32'h0,         3'b010});
        ops.push_back('{1, A_PRE,           32'h0,         3'b000});
        foreach (ops[k]) begin
            if (ops[k].is_rd) begin
                @(negedge clk);
                issue_rd(ops[k].a, 1'b1, ops[k].d);
                e = rd_q.pop_front();
                checks++;
                if ({rd_hit, rd_data} !== e) begin
                    failures++;
                    $display("FAIL regs_op%0d %h: got hit=%b data=%h, expected hit=%b data=%h", k, ops[k].a, rd_hit, rd_data, e[32], e[31:0]);
                end
            end else begin
                wr(ops[k].a, ops[k].d, ops[k].f3);
            end
        end
    endtask

    task automatic test_duty();
        int exp_d[NUM_CH];
        int e;
        exp_d = '{64, 0, 128, 255};
        for (int c = 0; c < NUM_CH; c++) wrw(a_duty(c), 32'(exp_d[c]));
        wrw(A_CTRL, 32'h1);
        repeat (300) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) cnt_q.push_back(exp_d[c]);
        count_win(PERIOD);
        for (int c = 0; c < NUM_CH; c++) begin
            e = cnt_q.pop_front();
            checks++;
            if (hi_cnt[c] !== e) begin
                failures++;
                $display("FAIL duty_ch%0d: got %0d high clocks, expected %0d", c, hi_cnt[c], e);
            end
        end
    endtask

    task automatic test_midperiod();
        bit ok;
        int e;
        align_ch0(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mid_align: got no rising edge, expected one within %0d clocks", 4 * PERIOD);
        end
        cnt_q.push_back(64);
        hi_cnt[0] = 0;
        for (int s = 0; s < PERIOD; s++) begin
            hi_cnt[0] += int'(pwm_out[0]);
            if (s == 100) begin
                mem_wen = 1'b1; mem_wa = a_duty(0); mem_wd = 32'd192; mem_funct3 = 3'b010;
            end
            if (s == 101) mem_wen = 1'b0;
            @(negedge clk);
        end
        e = cnt_q.pop_front();
        checks++;
        if (hi_cnt[0] !== e) begin
            failures++;
            $display("FAIL mid_current_period: got %0d high clocks, expected %0d", hi_cnt[0], e);
        end
        cnt_q.push_back(192);
        count_win(PERIOD);
        e = cnt_q.pop_front();
        checks++;
        if (hi_cnt[0] !== e) begin
            failures++;
            $display("FAIL mid_next_period: got %0d high clocks, expected %0d", hi_cnt[0], e);
        end
    endtask

    task automatic test_fade();
        bit ok;
        int lvl, dn, e;
        int inv_exp[NUM_CH];
        wrw(A_CTRL, 32'h0);
        wrw(a_duty(0), 32'd128);
        wrw(a_duty(1), 32'd3);
        wrw(a_duty(2), 32'd0);
        wrw(a_fade(1), 32'h1);
        wrw(A_CTRL, 32'h1);
        align_ch0(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL fade_align: got no rising edge, expected one within %0d clocks", 4 * PERIOD);
        end
        lvl = 0; dn = 0;
        for (int p = 0; p < 10; p++) begin
            cnt_q.push_back(lvl);
            count_win(PERIOD);
            e = cnt_q.pop_front();
            checks++;
            if (hi_cnt[1] !== e) begin
                failures++;
                $display("FAIL fade_period%0d: got %0d high clocks, expected %0d", p, hi_cnt[1], e);
            end
            if (dn == 0) begin
                if (lvl < 3) lvl++; else dn = 1;
            end else begin
                if (lvl > 0) lvl--; else dn = 0;
            end
        end
        wrw(A_CTRL, 32'h3);
        repeat (300) @(negedge clk);
        inv_exp = '{PERIOD - 128, -1, PERIOD, PERIOD - 255};
        for (int c = 0; c < NUM_CH; c++) if (c != 1) cnt_q.push_back(inv_exp[c]);
        count_win(PERIOD);
        for (int c = 0; c < NUM_CH; c++) begin
            if (c != 1) begin
                e = cnt_q.pop_front();
                checks++;
                if (hi_cnt[c] !== e) begin
                    failures++;
                    $display("FAIL invert_ch%0d: got %0d high clocks, expected %0d", c, hi_cnt[c], e);
                end
            end
        end
    endtask

    task automatic test_prescale();
        logic [32:0] e;
        int exp_cnt;
        wrw(A_CTRL, 32'h0);
        wrw(a_fade(1), 32'h0);
        wrw(A_PRE, 32'h3);
        wrw(A_CTRL, 32'h1);
        // PRESCALE=1 written mid-interval must wait for the tick after it
        for (int j = 0; j < 16; j++) begin
            if (j == 5) begin
                mem_wen = 1'b1; mem_wa = A_PRE; mem_wd = 32'h1; mem_funct3 = 3'b010;
            end
            if (j == 6) mem_wen = 1'b0;
            exp_cnt = (j < 8) ? j / 4 : 2 + (j - 8) / 2;
            issue_rd(A_STAT, 1'b1, 32'(exp_cnt));
            e = rd_q.pop_front();
            checks++;
            if ({rd_hit, rd_data} !== e) begin
                failures++;
                $display("FAIL prescale_status%0d: got hit=%b data=%h, expected hit=%b data=%h", j, rd_hit, rd_data, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e;
        logic [31:0] addrs[8];
        logic [32:0] exps[8];
        mem_ra = a_duty(2);
        mem_wen = 1'b1; mem_wa = a_duty(2); mem_wd = 32'h5A; mem_funct3 = 3'b010;
        rd_q.push_back({1'b1, 32'h0});
        @(negedge clk);
        mem_wen = 1'b0;
        e = rd_q.pop_front();
        checks++;
        if ({rd_hit, rd_data} !== e) begin
            failures++;
            $display("FAIL rw_same_cycle: got hit=%b data=%h, expected hit=%b data=%h", rd_hit, rd_data, e[32], e[31:0]);
        end
        addrs = '{a_duty(2), A_PRE, A_CTRL, a_fade(1), 32'h0000_1000, BASE + 32'h40, 32'hFFFF_FE08, a_duty(1)};
        exps  = '{{1'b1, 32'h5A}, {1'b1, 32'h1}, {1'b1, 32'h1}, {1'b1, 32'h0},
                  {1'b0, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'h0}, {1'b1, 32'h3}};
        for (int k = 0; k < 8; k++) begin
            issue_rd(addrs[k], exps[k][32], exps[k][31:0]);
            e = rd_q.pop_front();
            checks++;
            if ({rd_hit, rd_data} !== e) begin
                failures++;
                $display("FAIL b2b_read%0d %h: got hit=%b data=%h, expected hit=%b data=%h", k, addrs[k], rd_hit, rd_data, e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] e;
        logic [31:0] addrs[6];
        repeat (137) @(negedge clk);
        mem_ra = A_CTRL;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (pwm_out !== '0 || rd_hit !== 1'b0 || rd_data !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got pwm=%b hit=%b data=%h, expected all zero", pwm_out, rd_hit, rd_data);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (pwm_out !== '0) begin
            failures++;
            $display("FAIL midreset_pwm_held: got %b, expected 0", pwm_out);
        end
        addrs = '{A_CTRL, A_PRE, a_duty(0), a_duty(3), a_fade(1), A_STAT};
        for (int k = 0; k < 6; k++) begin
            issue_rd(addrs[k], 1'b1, 32'h0);
            e = rd_q.pop_front();
            checks++;
            if ({rd_hit, rd_data} !== e) begin
                failures++;
                $display("FAIL midreset_read %h: got hit=%b data=%h, expected hit=%b data=%h", addrs[k], rd_hit, rd_data, e[32], e[31:0]);
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_regs();
        test_duty();
        test_midperiod();
        test_fade();
        test_prescale();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_pwm_led.md
Name: mmio_pwm_led

Overview:
- Memory-mapped, N-channel PWM LED controller; replaces the fixed LED/RGB output bits currently driven from the memory block.
- Sits beside the memory on the core's data bus and decodes its own 256-byte address window.
- Provides per-channel duty cycle, a global prescaler, output polarity inversion, and an optional per-channel "breathe" fade mode.

Parameters:
- NUM_CH, 4, number of PWM channels (1..8).
- PWM_WIDTH, 8, bits of duty/period counter (4..16); period = 2^PWM_WIDTH ticks.
- BASE_ADDR, 32'hFFFF_FF00, window base; must be 256-byte aligned.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- mem_wen  input  1  write strobe from core.
- mem_wa  input  32  write byte address.
- mem_wd  input  32  write data, right-aligned for sub-word stores.
- mem_funct3  input  3  store size: 000 byte, 001 half, 010 word; others ignored.
- mem_ra  input  32  read byte address.
- rd_data  output  32  registered read data.
- rd_hit  output  1  registered: previous-cycle mem_ra was inside the window.
- pwm_out  output  NUM_CH  channel outputs, registered.

Behaviour:
- Hit decode: addr[31:8] == BASE_ADDR[31:8]; offset = addr[7:0].
- Register map (word offsets):
  - 0x00 CTRL: bit0 enable, bit1 invert; reset 0.
  - 0x04 PRESCALE: bits 15:0; reset 0.
  - 0x08 STATUS (RO): bits PWM_WIDTH-1:0 = period counter.
  - 0x10+8*i DUTY_i: bits PWM_WIDTH-1:0; reset 0.
  - 0x14+8*i FADE_i: bit0 fade enable; reset 0.
  - Unmapped offsets and channels >= NUM_CH read 0; writes to them are ignored.
- Writes:
  - Single cycle, taken when mem_wen and hit.
  - Byte store merges into byte addr[1:0]; half store merges into half addr[1].
  - Misaligned stores are dropped with no state change: half with addr[0]=1, word with addr[1:0]!=0.
  - Unsupported funct3 values are dropped.
  - Bits beyond a register's width are discarded; writes to STATUS are ignored.
- Reads:
  - One-cycle latency; rd_data/rd_hit reflect mem_ra of the previous cycle.
  - Read data comes from the word at addr[7:2].
  - Non-hit reads give rd_data=0 and rd_hit=0.
  - A read and a write to the same register in the same cycle return the old value.
- Prescaler:
  - 16-bit counter; produces tick for one cycle every PRESCALE+1 clocks, then reloads to 0.
  - A PRESCALE write takes effect at the next tick boundary.
- Period counter:
  - PWM_WIDTH bits; increments on tick and wraps 2^W-1 -> 0.
  - The wrap tick is period_end.
  - When enable=0, prescaler and counter are held at 0.
- Shadowing:
  - DUTY_i is copied to shadow_i at period_end, or immediately while enable=0.
  - Mid-period duty writes never glitch the output.
- Fade state, per channel:
  - level_i (PWM_WIDTH bits), dir_i (0 up, 1 down).
  - At period_end with fade on, dir=0: if level<shadow, level+1; else dir<=1.
  - At period_end with fade on, dir=1: if level>0, level-1; else dir<=0.
  - If shadow drops below level while going up, clamp level to shadow and set dir=1.
  - Fade off: level=0, dir=0, and effective duty = shadow.
  - Fade on: effective duty = level.
- Output:
  - pwm_out[i] <= enable & (cnt < eff_duty_i), XOR invert; registered, so one cycle after cnt.
  - duty 0 gives always low before invert.
  - duty 2^W-1 gives high for 2^W-1 of 2^W ticks.
- Reset:
  - All registers, counters, shadows, levels, dir, rd_data and rd_hit go to 0; pwm_out goes to 0.
  - Asserting rst_n=0 mid-period clears everything on that edge; there is no partial state retained.
  - Invert is reset 0, so outputs are low after reset.

Test Plan:
- Reset then word read at 0xFFFF_FF00 -> next cycle rd_hit=1, rd_data=0; pwm_out=0.
- CTRL=1, PRESCALE=0, DUTY_0=64 -> pwm_out[0] high exactly 64 of every 256 clocks; DUTY_0=0 -> never high; DUTY_0=255 -> high 255/256.
- DUTY_0=64 running, write DUTY_0=192 at cnt=100 -> remainder of current period unchanged; next period high 192 clocks.
- Byte store 0xAB at offset 0x11 (funct3=000) onto DUTY_0=0x0000_0012 (PWM_WIDTH=16) -> reads 0x0000_AB12; half store at 0x13 -> dropped, value unchanged.
- FADE_1=1, DUTY_1=3, PRESCALE=0, PWM_WIDTH=4 -> level per period 1,2,3,3(dir flip),2,1,0,0(flip),1...; CTRL.invert=1 -> output complemented.
- PRESCALE=3 -> STATUS increments every 4 clocks; rst_n low for 1 cycle mid-period -> all outputs/registers 0 next cycle; read outside window -> rd_hit=0, rd_data=0.
